opb_register_bank: RTL and testbench

//  Parametrised OPB slave exposing NUM_REGS 32-bit software registers, each with a per-register mode:
//  - RW: read/write control.
//  - RO: read-only status from fabric.
//  - W1C: sticky event bits.
//  - PULSE: self-clearing command.

---
 rtl/opb_regbank_pkg.sv | 51 +++++
 rtl/opb_reg_cell.sv | 62 ++++++
 rtl/opb_register_bank.sv | 139 +++++++++++++
 tb/tb_opb_register_bank.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/opb_regbank_pkg.sv
// Shared definitions for the OPB register bank.
//   MODE_*        per-register behaviour codes (2 bits each in REG_MODE)
//   decode_t      result of an address decode: hit flag and word index
//   ack_state_t   two-state acknowledge FSM encoding
//   be_to_mask    expands a 4-bit byte-enable (bit 3 = most significant byte) into a 32-bit mask
//   decode_addr   decides whether an address falls on a register and which one
package opb_regbank_pkg;

   localparam logic [1:0] MODE_RW    = 2'b00;
   localparam logic [1:0] MODE_RO    = 2'b01;
   localparam logic [1:0] MODE_W1C   = 2'b10;
   localparam logic [1:0] MODE_PULSE = 2'b11;

   // Wide enough for the largest bank (64 registers).
   localparam int IDX_W = 6;

   typedef struct packed {
      logic             hit;
      logic [IDX_W-1:0] idx;
   } decode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } ack_state_t;

   function automatic logic [31:0] be_to_mask(input logic [3:0] be);
      logic [31:0] mask;
      for (int b = 0; b < 4; b++) begin
         mask[8*b +: 8] = {8{be[b]}};
      end
      return mask;
   endfunction

   // The window is limited both by the register count and by the
   // configured high address, whichever is tighter.
   function automatic decode_t decode_addr(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] high,
                                           input int unsigned num_regs);
      decode_t     d;
      logic [31:0] offset;
      logic [31:0] span;
      offset = addr - base;
      span   = num_regs << 2;
      d.hit  = (addr >= base) && (addr <= high) && (offset < span);
      d.idx  = IDX_W'(offset >> 2);
      return d;
   endfunction

endpackage

// File: rtl/opb_reg_cell.sv
// One 32-bit software register.
//   clk, rst_n   clock and asynchronous active-low reset
//   wr_en        software write this cycle
//   wr_data      write data, bit 31 = most significant
//   wr_mask      per-bit write mask built from the byte enables
//   set          fabric set pulses (only meaningful in W1C mode)
//   q            current register value
// MODE selects RW / RO / W1C / PULSE behaviour; RESET_VAL is the value after reset.
module opb_reg_cell
   import opb_regbank_pkg::*;
#(
   parameter logic [1:0]  MODE      = MODE_RW,
   parameter logic [31:0] RESET_VAL = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   input  logic [31:0] wr_mask,
   input  logic [31:0] set,
   output logic [31:0] q
);

   logic [31:0] q_reg;
   logic [31:0] q_next;
   logic [31:0] replaced;

   // Some modes ignore some inputs; fold them here so every port is consumed.
   logic unused_inputs;
   assign unused_inputs = ^{wr_en, wr_data, wr_mask, set};

   always_comb begin
      replaced = (q_reg & ~wr_mask) | (wr_data & wr_mask);
      q_next   = q_reg;
      case (MODE)
         MODE_RW: begin
            if (wr_en) q_next = replaced;
         end
         MODE_RO: begin
            q_next = q_reg;
         end
         MODE_W1C: begin
            if (wr_en) q_next = q_reg & ~(wr_data & wr_mask);
            // Applied after the clear so a simultaneous set survives.
            q_next = q_next | set;
         end
         MODE_PULSE: begin
            // Holds the written value for exactly one cycle.
            q_next = wr_en ? replaced : RESET_VAL;
         end
         default: q_next = q_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_reg <= RESET_VAL;
      else        q_reg <= q_next;
   end

   assign q = q_reg;

endmodule

// File: rtl/opb_register_bank.sv
// OPB slave exposing NUM_REGS 32-bit software registers with per-register modes.
//   OPB_Clk, OPB_Rst_n         clock and asynchronous active-low reset
//   OPB_ABus/BE/DBus/RNW       OPB request (big-endian bit numbering, bit 0 = MSB)
//   OPB_select, OPB_seqAddr    transfer request; sequential hint is ignored
//   Sl_DBus, Sl_xferAck        read data and acknowledge, both valid one cycle after a hit
//   Sl_errAck/retry/toutSup    tied low
//   user_data_out              register contents, reg i at [32i+31:32i]
//   user_data_in               RO read sources, reg i at [32i+31:32i]
//   user_set                   W1C set pulses, reg i at [32i+31:32i]
//   user_wr_strobe             one-cycle pulse per register after a software write
module opb_register_bank
   import opb_regbank_pkg::*;
#(
   parameter logic [31:0]             C_BASEADDR   = 32'h01060000,
   parameter logic [31:0]             C_HIGHADDR   = 32'h010600FF,
   parameter int                      C_OPB_AWIDTH = 32,
   parameter int                      C_OPB_DWIDTH = 32,
   parameter int                      NUM_REGS     = 8,
   parameter logic [2*NUM_REGS-1:0]   REG_MODE     = '0,
   parameter logic [32*NUM_REGS-1:0]  REG_RESET    = '0
) (
   input  logic                      OPB_Clk,
   input  logic                      OPB_Rst_n,
   input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
   input  logic [0:3]                OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
   input  logic                      OPB_RNW,
   input  logic                      OPB_select,
   input  logic                      OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
   output logic                      Sl_errAck,
   output logic                      Sl_retry,
   output logic                      Sl_toutSup,
   output logic                      Sl_xferAck,
   output logic [32*NUM_REGS-1:0]    user_data_out,
   input  logic [32*NUM_REGS-1:0]    user_data_in,
   input  logic [32*NUM_REGS-1:0]    user_set,
   output logic [NUM_REGS-1:0]       user_wr_strobe
);

   // Vector assignment is positional, so OPB bit 0 lands on bit 31 and
   // OPB_BE[0] lands on be[3] (the most significant byte).
   logic [31:0]   addr;
   logic [31:0]   wdata;
   logic [3:0]    be;
   logic [31:0]   wr_mask;
   decode_t       dec;
   logic          hit;
   logic          wr_hit;
   logic [31:0]   rd_data;
   logic [31:0]   reg_q [NUM_REGS];
   logic [NUM_REGS-1:0] cell_we;
   logic [NUM_REGS-1:0] strobe_next;

   ack_state_t          state_reg;
   logic                ack_reg;
   logic [31:0]         dbus_reg;
   logic [NUM_REGS-1:0] strobe_reg;

   logic unused_top;
   assign unused_top = ^{OPB_seqAddr, user_data_in};

   assign addr    = OPB_ABus;
   assign wdata   = OPB_DBus;
   assign be      = OPB_BE;
   assign wr_mask = be_to_mask(be);
   assign dec     = decode_addr(addr, C_BASEADDR, C_HIGHADDR, NUM_REGS);

   // No new hit while acknowledging, which forces a gap between acks.
   assign hit    = OPB_select && dec.hit && (state_reg == ST_IDLE);
   assign wr_hit = hit && !OPB_RNW;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         localparam logic [1:0] CELL_MODE = REG_MODE[2*gi +: 2];

         assign cell_we[gi]     = wr_hit && (dec.idx == IDX_W'(gi));
         assign strobe_next[gi] = cell_we[gi] && (CELL_MODE != MODE_RO);

         opb_reg_cell #(
            .MODE      (CELL_MODE),
            .RESET_VAL (REG_RESET[32*gi +: 32])
         ) u_cell (
            .clk     (OPB_Clk),
            .rst_n   (OPB_Rst_n),
            .wr_en   (cell_we[gi]),
            .wr_data (wdata),
            .wr_mask (wr_mask),
            .set     (user_set[32*gi +: 32]),
            .q       (reg_q[gi])
         );

         assign user_data_out[32*gi +: 32] = reg_q[gi];
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (dec.idx == IDX_W'(i)) begin
            rd_data = (REG_MODE[2*i +: 2] == MODE_RO) ? user_data_in[32*i +: 32] : reg_q[i];
         end
      end
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state_reg  <= ST_IDLE;
         ack_reg    <= 1'b0;
         dbus_reg   <= '0;
         strobe_reg <= '0;
      end else begin
         ack_reg    <= 1'b0;
         dbus_reg   <= '0;
         strobe_reg <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (hit) begin
                  state_reg  <= ST_ACK;
                  ack_reg    <= 1'b1;
                  dbus_reg   <= OPB_RNW ? rd_data : '0;
                  strobe_reg <= strobe_next;
               end
            end
            ST_ACK:  state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign Sl_xferAck     = ack_reg;
   assign Sl_DBus        = dbus_reg;
   assign user_wr_strobe = strobe_reg;
   assign Sl_errAck      = 1'b0;
   assign Sl_retry       = 1'b0;
   assign Sl_toutSup     = 1'b0;

endmodule

// File: tb/tb_opb_register_bank.sv
module tb_opb_register_bank;

   localparam int          N    = 8;
   localparam logic [31:0] BASE = 32'h01060000;
   localparam logic [31:0] HIGH = 32'h010600FF;

   // reg0 RW, reg1 RW, reg2 W1C, reg3 RW, reg4 RO, reg5 PULSE, reg6 RW, reg7 W1C
   int          mode_of  [N] = '{0, 0, 2, 0, 1, 3, 0, 2};
   logic [31:0] reset_of [N] = '{32'h0, 32'h0, 32'h0, 32'hA5A5_0000,
                                 32'h0, 32'h0, 32'h1234_5678, 32'h0000_00F0};
   logic [31:0] model    [N];

   logic          clk = 1'b0;
   logic          rst_n;
   logic [0:31]   abus;
   logic [0:3]    be;
   logic [0:31]   dbus;
   logic          rnw, sel, seq;
   logic [0:31]   sl_dbus;
   logic          err_ack, retry, tout_sup, xfer_ack;
   logic [255:0]  udo, udi, uset;
   logic [N-1:0]  strobe;

   int n_tests = 0;
   int n_fail  = 0;

   opb_register_bank #(
      .C_BASEADDR   (BASE),
      .C_HIGHADDR   (HIGH),
      .C_OPB_AWIDTH (32),
      .C_OPB_DWIDTH (32),
      .NUM_REGS     (N),
      .REG_MODE     (16'h8D20),
      .REG_RESET    ({32'h0000_00F0, 32'h1234_5678, 32'h0, 32'h0,
                      32'hA5A5_0000, 32'h0, 32'h0, 32'h0})
   ) dut (
      .OPB_Clk        (clk),
      .OPB_Rst_n      (rst_n),
      .OPB_ABus       (abus),
      .OPB_BE         (be),
      .OPB_DBus       (dbus),
      .OPB_RNW        (rnw),
      .OPB_select     (sel),
      .OPB_seqAddr    (seq),
      .Sl_DBus        (sl_dbus),
      .Sl_errAck      (err_ack),
      .Sl_retry       (retry),
      .Sl_toutSup     (tout_sup),
      .Sl_xferAck     (xfer_ack),
      .user_data_out  (udo),
      .user_data_in   (udi),
      .user_set       (uset),
      .user_wr_strobe (strobe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) model[i] = reset_of[i];
   endtask

   // Byte lane k of the OPB bus carries register bits [31-8k : 24-8k].
   task automatic model_write(input int i, input logic [0:3] b, input logic [31:0] d);
      for (int k = 0; k < 4; k++) begin
         if (b[k]) begin
            int          lo;
            logic [31:0] byte_v;
            lo     = 24 - 8*k;
            byte_v = (d >> lo) & 32'hFF;
            case (mode_of[i])
               0, 3:    model[i] = (model[i] & ~(32'hFF << lo)) | (byte_v << lo);
               2:       model[i] = model[i] & ~(byte_v << lo);
               default: ;
            endcase
         end
      end
   endtask

   task automatic model_set(input logic [255:0] s);
      for (int i = 0; i < N; i++) if (mode_of[i] == 2) model[i] = model[i] | s[32*i +: 32];
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < N; i++) chk($sformatf("%s reg%0d", tag, i), udo[32*i +: 32], model[i]);
   endtask

   // One single-beat transfer; select is dropped in the ack cycle.
   task automatic xfer(input string tag, input int i, input bit r, input logic [0:3] b,
                       input logic [31:0] d, input logic [255:0] s);
      logic [31:0] exp_rd;
      for (int k = 0; k < N; k++) udi[32*k +: 32] = $urandom;
      abus = BASE + 32'(4*i); be = b; dbus = d; rnw = r; sel = 1'b1; uset = s;
      exp_rd = (mode_of[i] == 1) ? udi[32*i +: 32] : model[i];
      if (!r) model_write(i, b, d);
      model_set(s);
      @(posedge clk); #1;
      sel = 1'b0; uset = '0;
      chk({tag, " ack"}, 32'(xfer_ack), 32'd1);
      chk({tag, " strobe"}, 32'(strobe), (!r && mode_of[i] != 1) ? (32'd1 << i) : 32'd0);
      chk({tag, " dbus"}, sl_dbus, r ? exp_rd : 32'd0);
      chk({tag, " reg"}, udo[32*i +: 32], model[i]);
      $display("[TB] %s: %s reg%0d be=%b d=%h -> reg=%h dbus=%h", tag, r ? "RD" : "WR",
               i, b, d, udo[32*i +: 32], sl_dbus);
      if (!r && mode_of[i] == 3) model[i] = reset_of[i];
      @(posedge clk); #1;
      chk({tag, " ack gap"}, 32'(xfer_ack), 32'd0);
      chk({tag, " strobe gap"}, 32'(strobe), 32'd0);
      chk({tag, " reg after"}, udo[32*i +: 32], model[i]);
   endtask

   initial begin
      logic [255:0] s;
      rst_n = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel = 1'b0; seq = 1'b0;
      udi = '0; uset = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset reg3", udo[96 +: 32], 32'hA5A5_0000);
      chk("reset ack", 32'(xfer_ack), 32'd0);
      chk("reset dbus", sl_dbus, 32'd0);
      chk("reset strobe", 32'(strobe), 32'd0);
      chk("tied outputs", {29'd0, err_ack, retry, tout_sup}, 32'd0);
      check_all("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // RW full word, byte write, readback
      xfer("rw full", 0, 1'b0, 4'b1111, 32'hDEAD_BEEF, '0);
      xfer("rw byte", 0, 1'b0, 4'b0100, 32'h0011_2233, '0);
      chk("rw byte value", udo[0 +: 32], 32'hDE11_BEEF);
      xfer("rw read", 0, 1'b1, 4'b1111, 32'h0, '0);

      // W1C: fabric set, set-vs-clear collision, clear alone
      uset = '0; uset[64 +: 32] = 32'h5; model_set(uset);
      @(posedge clk); #1;
      uset = '0;
      chk("w1c set", udo[64 +: 32], 32'h5);
      s = '0; s[64 +: 32] = 32'h1;
      xfer("w1c collide", 2, 1'b0, 4'b1111, 32'h1, s);
      chk("w1c set wins", udo[64 +: 32], 32'h5);
      xfer("w1c clear", 2, 1'b0, 4'b1111, 32'h4, '0);
      chk("w1c cleared", udo[64 +: 32], 32'h1);

      // PULSE self-clear, RO write ignored but strobe-free, BE=0000 write
      xfer("pulse", 5, 1'b0, 4'b1111, 32'h1, '0);
      xfer("ro write", 4, 1'b0, 4'b1111, 32'hFFFF_FFFF, '0);
      xfer("ro read", 4, 1'b1, 4'b1111, 32'h0, '0);
      xfer("be zero", 6, 1'b0, 4'b0000, 32'hFFFF_FFFF, '0);

      // Held select: acks only every other cycle
      abus = BASE + 32'd4; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
      chk("held c1", 32'(xfer_ack), 32'd0);
      for (int c = 2; c <= 6; c++) begin
         @(posedge clk); #1;
         chk($sformatf("held c%0d", c), 32'(xfer_ack), (c % 2 == 0) ? 32'd1 : 32'd0);
      end
      sel = 1'b0;
      @(posedge clk); #1;

      // Just past the last register: never acked
      abus = BASE + 32'(4*N); sel = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk("no hit ack", 32'(xfer_ack), 32'd0);
      end
      sel = 1'b0;
      @(posedge clk); #1;

      // Randomized mix against the reference model
      for (int t = 0; t < 60; t++) begin
         int          i;
         logic [31:0] d;
         logic [0:3]  b;
         bit          r;
         i = $urandom_range(0, N-1);
         r = 1'($urandom_range(0, 1));
         b = 4'($urandom);
         d = $urandom;
         s = '0;
         if ($urandom_range(0, 2) == 0) s[64 +: 32]  = $urandom & $urandom;
         if ($urandom_range(0, 2) == 0) s[224 +: 32] = $urandom & $urandom;
         xfer($sformatf("rand%0d", t), i, r, b, d, s);
      end
      check_all("after random");

      // Reset in the ack cycle
      abus = BASE; be = 4'b1111; dbus = 32'hCAFE_F00D; rnw = 1'b0; sel = 1'b1;
      @(posedge clk); #1;
      chk("pre-reset ack", 32'(xfer_ack), 32'd1);
      rst_n = 1'b0;
      #1;
      sel = 1'b0;
      model_reset();
      chk("async reset ack", 32'(xfer_ack), 32'd0);
      chk("async reset strobe", 32'(strobe), 32'd0);
      check_all("async reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post reset ack", 32'(xfer_ack), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
